// File: rtl/roce_pkg.sv
// roce_pkg: shared widths and types for the RoCE TX arbiter.
package roce_pkg;

  localparam int unsigned ROCE_N_CHAN      = 4;
  localparam int unsigned ROCE_META_W      = 160;
  localparam int unsigned ROCE_DATA_W      = 512;
  localparam int unsigned ROCE_GRANT_DEPTH = 8;
  localparam int unsigned ROCE_CHAN_W      = (ROCE_N_CHAN > 1) ? $clog2(ROCE_N_CHAN) : 1;

  typedef logic [ROCE_META_W-1:0] roce_meta_t;
  typedef logic [ROCE_CHAN_W-1:0] roce_chan_t;

endpackage

// File: rtl/roce_grant_fifo.sv
// roce_grant_fifo: synchronous FIFO of granted channel indices, registered full/empty.
module roce_grant_fifo
  import roce_pkg::*;
#(
  parameter int unsigned W     = ROCE_CHAN_W,
  parameter int unsigned DEPTH = ROCE_GRANT_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok, pop_ok;

  // Next-state for storage, pointers, occupancy and flags
  always_comb begin
    push_ok  = push && !full_q;
    pop_ok   = pop && !empty_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    cnt_d   = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    full_d  = (cnt_d == CNT_W'(DEPTH));
    empty_d = (cnt_d == '0);
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/roce_tx_arbiter.sv
// roce_tx_arbiter: round-robin meta arbiter feeding core tx_meta, with data steered
// onto tx_data in grant order. Define ROCE_TX_STATS_EN for per-channel counters.
module roce_tx_arbiter
  import roce_pkg::*;
#(
  parameter int unsigned N_CHAN      = ROCE_N_CHAN,
  parameter int unsigned META_W      = ROCE_META_W,
  parameter int unsigned DATA_W      = ROCE_DATA_W,
  parameter int unsigned GRANT_DEPTH = ROCE_GRANT_DEPTH
) (
  input  logic                         net_clk,
  input  logic                         net_areset,
  input  logic [N_CHAN-1:0]            s_meta_valid,
  output logic [N_CHAN-1:0]            s_meta_ready,
  input  logic [N_CHAN*META_W-1:0]     s_meta_data,
  input  logic [N_CHAN-1:0]            s_meta_has_data,
  input  logic [N_CHAN-1:0]            s_data_valid,
  output logic [N_CHAN-1:0]            s_data_ready,
  input  logic [N_CHAN*DATA_W-1:0]     s_data_data,
  input  logic [N_CHAN*DATA_W/8-1:0]   s_data_keep,
  input  logic [N_CHAN-1:0]            s_data_last,
  output logic                         m_meta_valid,
  input  logic                         m_meta_ready,
  output logic [META_W-1:0]            m_meta_data,
  output logic [$clog2(N_CHAN)-1:0]    m_meta_dest,
  output logic                         m_data_valid,
  input  logic                         m_data_ready,
  output logic [DATA_W-1:0]            m_data_data,
  output logic [DATA_W/8-1:0]          m_data_keep,
  output logic                         m_data_last,
  output logic                         grant_fifo_full
`ifdef ROCE_TX_STATS_EN
  ,
  output logic [N_CHAN*32-1:0]         stat_pkt_cnt,
  output logic [N_CHAN*32-1:0]         stat_meta_cnt
`endif
);

  localparam int unsigned CW     = $clog2(N_CHAN);
  localparam int unsigned KEEP_W = DATA_W / 8;

  logic [CW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              meta_vld_q, meta_vld_d;
  logic [META_W-1:0] meta_data_q, meta_data_d;
  logic [CW-1:0]     meta_dest_q, meta_dest_d;

  logic              grant_vld_c;
  logic [CW-1:0]     grant_idx_c;
  logic              load_en_c;
  logic              accept_c;
  logic              fifo_push_c;
  logic              fifo_pop_c;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_head;

  // First eligible channel at or after rr_ptr; payload requests need a free grant slot
  always_comb begin
    logic [CW:0] idx;
    grant_vld_c = 1'b0;
    grant_idx_c = '0;
    idx         = '0;
    for (int unsigned k = 0; k < N_CHAN; k++) begin
      idx = {1'b0, rr_ptr_q} + (CW+1)'(k);
      if (idx >= (CW+1)'(N_CHAN)) begin
        idx = idx - (CW+1)'(N_CHAN);
      end
      if (!grant_vld_c && s_meta_valid[idx[CW-1:0]] &&
          (!fifo_full || !s_meta_has_data[idx[CW-1:0]])) begin
        grant_vld_c = 1'b1;
        grant_idx_c = idx[CW-1:0];
      end
    end
  end

  // Accept into the meta output register, advance rr pointer, record payload grants
  always_comb begin
    load_en_c    = !meta_vld_q || m_meta_ready;
    accept_c     = load_en_c && grant_vld_c;
    s_meta_ready = '0;
    s_meta_ready[grant_idx_c] = accept_c;
    meta_vld_d   = meta_vld_q;
    meta_data_d  = meta_data_q;
    meta_dest_d  = meta_dest_q;
    rr_ptr_d     = rr_ptr_q;
    if (load_en_c) begin
      meta_vld_d = grant_vld_c;
    end
    if (accept_c) begin
      meta_data_d = s_meta_data[grant_idx_c*META_W +: META_W];
      meta_dest_d = grant_idx_c;
      rr_ptr_d    = (grant_idx_c == CW'(N_CHAN - 1)) ? '0 : grant_idx_c + CW'(1);
    end
    fifo_push_c = accept_c && s_meta_has_data[grant_idx_c];
  end

  // Steer the head-of-queue channel's data onto tx_data; pop on the last beat
  always_comb begin
    s_data_ready = '0;
    m_data_valid = 1'b0;
    m_data_data  = '0;
    m_data_keep  = '0;
    m_data_last  = 1'b0;
    if (!fifo_empty) begin
      m_data_valid = s_data_valid[fifo_head];
      m_data_data  = s_data_data[fifo_head*DATA_W +: DATA_W];
      m_data_keep  = s_data_keep[fifo_head*KEEP_W +: KEEP_W];
      m_data_last  = s_data_last[fifo_head];
      s_data_ready[fifo_head] = m_data_ready;
    end
    fifo_pop_c = m_data_valid && m_data_ready && m_data_last;
  end

  // Arbiter and meta output registers
  always_ff @(posedge net_clk or posedge net_areset) begin
    if (net_areset) begin
      rr_ptr_q    <= '0;
      meta_vld_q  <= 1'b0;
      meta_data_q <= '0;
      meta_dest_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      meta_vld_q  <= meta_vld_d;
      meta_data_q <= meta_data_d;
      meta_dest_q <= meta_dest_d;
    end
  end

  roce_grant_fifo #(
    .W     (CW),
    .DEPTH (GRANT_DEPTH)
  ) u_grant_fifo (
    .clk       (net_clk),
    .rst       (net_areset),
    .push      (fifo_push_c),
    .push_data (grant_idx_c),
    .pop       (fifo_pop_c),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign m_meta_valid    = meta_vld_q;
  assign m_meta_data     = meta_data_q;
  assign m_meta_dest     = meta_dest_q;
  assign grant_fifo_full = fifo_full;

`ifdef ROCE_TX_STATS_EN
  logic [31:0] pkt_cnt_q  [N_CHAN];
  logic [31:0] pkt_cnt_d  [N_CHAN];
  logic [31:0] meta_cnt_q [N_CHAN];
  logic [31:0] meta_cnt_d [N_CHAN];

  // Count delivered packets per head channel and meta grants per destination
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    meta_cnt_d = meta_cnt_q;
    if (fifo_pop_c) begin
      pkt_cnt_d[fifo_head] = pkt_cnt_q[fifo_head] + 32'd1;
    end
    if (meta_vld_q && m_meta_ready) begin
      meta_cnt_d[meta_dest_q] = meta_cnt_q[meta_dest_q] + 32'd1;
    end
  end

  // Statistics registers
  always_ff @(posedge net_clk or posedge net_areset) begin
    if (net_areset) begin
      for (int i = 0; i < int'(N_CHAN); i++) begin
        pkt_cnt_q[i]  <= '0;
        meta_cnt_q[i] <= '0;
      end
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      meta_cnt_q <= meta_cnt_d;
    end
  end

  // Flatten counters onto the status ports
  always_comb begin
    stat_pkt_cnt  = '0;
    stat_meta_cnt = '0;
    for (int i = 0; i < int'(N_CHAN); i++) begin
      stat_pkt_cnt[i*32 +: 32]  = pkt_cnt_q[i];
      stat_meta_cnt[i*32 +: 32] = meta_cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_roce_tx_arbiter.sv
// tb_roce_tx_arbiter: randomized traffic against a round-robin/grant-order reference model.
// Build with ROCE_TX_STATS_EN defined to also check the statistics counters.
module tb_roce_tx_arbiter;
  import roce_pkg::*;

  localparam int unsigned N     = ROCE_N_CHAN;
  localparam int unsigned MW    = ROCE_META_W;
  localparam int unsigned DW    = ROCE_DATA_W;
  localparam int unsigned KW    = DW / 8;
  localparam int unsigned DEPTH = ROCE_GRANT_DEPTH;
  localparam int unsigned CW    = ROCE_CHAN_W;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [MW-1:0] data;
    logic [CW-1:0] dest;
  } meta_t;

  logic              net_clk = 1'b0;
  logic              net_areset;
  logic [N-1:0]      s_meta_valid, s_meta_ready, s_meta_has_data;
  logic [N*MW-1:0]   s_meta_data;
  logic [N-1:0]      s_data_valid, s_data_ready, s_data_last;
  logic [N*DW-1:0]   s_data_data;
  logic [N*KW-1:0]   s_data_keep;
  logic              m_meta_valid, m_meta_ready;
  logic [MW-1:0]     m_meta_data;
  logic [CW-1:0]     m_meta_dest;
  logic              m_data_valid, m_data_ready, m_data_last;
  logic [DW-1:0]     m_data_data;
  logic [KW-1:0]     m_data_keep;
  logic              grant_fifo_full;
`ifdef ROCE_TX_STATS_EN
  logic [N*32-1:0]   stat_pkt_cnt, stat_meta_cnt;
  int unsigned       exp_pkt_cnt [N];
  int unsigned       exp_meta_cnt [N];
`endif

  roce_tx_arbiter dut (
    .net_clk         (net_clk),
    .net_areset      (net_areset),
    .s_meta_valid    (s_meta_valid),
    .s_meta_ready    (s_meta_ready),
    .s_meta_data     (s_meta_data),
    .s_meta_has_data (s_meta_has_data),
    .s_data_valid    (s_data_valid),
    .s_data_ready    (s_data_ready),
    .s_data_data     (s_data_data),
    .s_data_keep     (s_data_keep),
    .s_data_last     (s_data_last),
    .m_meta_valid    (m_meta_valid),
    .m_meta_ready    (m_meta_ready),
    .m_meta_data     (m_meta_data),
    .m_meta_dest     (m_meta_dest),
    .m_data_valid    (m_data_valid),
    .m_data_ready    (m_data_ready),
    .m_data_data     (m_data_data),
    .m_data_keep     (m_data_keep),
    .m_data_last     (m_data_last),
    .grant_fifo_full (grant_fifo_full)
`ifdef ROCE_TX_STATS_EN
    ,
    .stat_pkt_cnt    (stat_pkt_cnt),
    .stat_meta_cnt   (stat_meta_cnt)
`endif
  );

  always #5 net_clk = ~net_clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Scoreboard queues: per-channel payload (sent / expected), meta order, data grant order
  beat_t send_q [N][$];
  beat_t exp_q  [N][$];
  meta_t meta_q [$];
  int    grant_q [$];

  // Reference model state: rotation start, output-register occupancy, outstanding payload grants
  int unsigned rr_m;
  bit          occ_m;
  int unsigned cnt_m;
  bit          saw_full;

  logic [N-1:0] meta_hs, data_hs;
  bit           gen_en;
  int unsigned  p_meta, p_hd, p_data, p_rdy;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_wide();
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < int'(DW / 32); i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Source behaviour after each edge: retire accepted items, offer new ones, randomize sink readies
  task automatic drive_cycle();
    for (int c = 0; c < int'(N); c++) begin
      if (meta_hs[c]) begin
        s_meta_valid[c]    = 1'b0;
        s_meta_has_data[c] = 1'b0;
      end
      if (!s_meta_valid[c] && gen_en && ($urandom_range(99) < p_meta)) begin
        bit hd;
        hd = ($urandom_range(99) < p_hd);
        s_meta_data[c*MW +: MW] = MW'(rand_wide());
        s_meta_has_data[c]      = hd;
        s_meta_valid[c]         = 1'b1;
        if (hd) begin
          int unsigned nb;
          nb = $urandom_range(1, 4);
          for (int b = 0; b < int'(nb); b++) begin
            beat_t bt;
            bt.data = rand_wide();
            bt.last = (b == int'(nb) - 1);
            bt.keep = bt.last ? KW'(rand_wide()) : '1;
            send_q[c].push_back(bt);
            exp_q[c].push_back(bt);
          end
        end
      end
      if (data_hs[c]) begin
        void'(send_q[c].pop_front());
        s_data_valid[c] = 1'b0;
      end
      if (!s_data_valid[c] && send_q[c].size() > 0 && ($urandom_range(99) < p_data)) begin
        s_data_data[c*DW +: DW] = send_q[c][0].data;
        s_data_keep[c*KW +: KW] = send_q[c][0].keep;
        s_data_last[c]          = send_q[c][0].last;
        s_data_valid[c]         = 1'b1;
      end
    end
    m_meta_ready = ($urandom_range(99) < p_rdy);
    m_data_ready = ($urandom_range(99) < p_rdy);
  endtask

  // Just before the edge: predict which channel wins, check readies/flags, log expectations
  task automatic sample_cycle();
    logic [N-1:0] exp_rdy;
    bit full_m, load_ok, pop_now;
    int w;
    full_m  = (cnt_m == DEPTH);
    load_ok = !occ_m || m_meta_ready;
    w = -1;
    if (full_m) saw_full = 1'b1;
    if (load_ok) begin
      for (int k = 0; k < int'(N); k++) begin
        int c;
        c = (int'(rr_m) + k) % int'(N);
        if (w < 0 && s_meta_valid[c] && (!full_m || !s_meta_has_data[c])) w = c;
      end
    end
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    chk("s_meta_ready", DW'(s_meta_ready), DW'(exp_rdy));
    chk("grant_fifo_full", DW'(grant_fifo_full), DW'(full_m));
    chk("m_meta_valid", DW'(m_meta_valid), DW'(occ_m));
    meta_hs = s_meta_valid & s_meta_ready;
    data_hs = s_data_valid & s_data_ready;
    pop_now = m_data_valid && m_data_ready && m_data_last;
    if (w >= 0) begin
      meta_t e;
      e.data = s_meta_data[w*MW +: MW];
      e.dest = CW'(w);
      meta_q.push_back(e);
      rr_m = (w + 1) % int'(N);
      if (s_meta_has_data[w]) begin
        grant_q.push_back(w);
        cnt_m++;
      end
    end
    if (pop_now && cnt_m > 0) cnt_m--;
    occ_m = (w >= 0) ? 1'b1 : (m_meta_ready ? 1'b0 : occ_m);
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge net_clk); #1;
      drive_cycle();
      #7;
      sample_cycle();
    end
  endtask

  task automatic set_mix(input int unsigned pm, input int unsigned ph, input int unsigned pd,
                         input int unsigned pr);
    p_meta = pm; p_hd = ph; p_data = pd; p_rdy = pr;
  endtask

  // Async reset pulse: upstream also drops everything, model returns to its initial state
  task automatic do_reset();
    @(posedge net_clk); #1;
    net_areset      = 1'b1;
    s_meta_valid    = '0;
    s_meta_has_data = '0;
    s_data_valid    = '0;
    s_data_last     = '0;
    m_meta_ready    = 1'b0;
    m_data_ready    = 1'b0;
    for (int c = 0; c < int'(N); c++) begin
      send_q[c].delete();
      exp_q[c].delete();
    end
    meta_q.delete();
    grant_q.delete();
    rr_m = 0; occ_m = 1'b0; cnt_m = 0;
    meta_hs = '0; data_hs = '0;
    #7;
    chk("rst_m_meta_valid", DW'(m_meta_valid), '0);
    chk("rst_m_data_valid", DW'(m_data_valid), '0);
    chk("rst_grant_fifo_full", DW'(grant_fifo_full), '0);
    chk("rst_s_data_ready", DW'(s_data_ready), '0);
    @(posedge net_clk); #1;
    net_areset = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUT completes an output handshake
  initial begin
    forever begin
      @(posedge net_clk); #7;
      if (net_areset) begin
`ifdef ROCE_TX_STATS_EN
        for (int c = 0; c < int'(N); c++) begin
          exp_pkt_cnt[c] = 0; exp_meta_cnt[c] = 0;
        end
`endif
      end else begin
        if (m_meta_valid && m_meta_ready) begin
          chk("meta_expected", DW'(meta_q.size() != 0), DW'(1));
          if (meta_q.size() != 0) begin
            meta_t e;
            e = meta_q.pop_front();
            chk("m_meta_data", DW'(m_meta_data), DW'(e.data));
            chk("m_meta_dest", DW'(m_meta_dest), DW'(e.dest));
`ifdef ROCE_TX_STATS_EN
            exp_meta_cnt[e.dest]++;
`endif
          end
        end
        if (m_data_valid && m_data_ready) begin
          chk("data_grant_expected", DW'(grant_q.size() != 0), DW'(1));
          if (grant_q.size() != 0) begin
            int ch;
            ch = grant_q[0];
            chk("data_beat_expected", DW'(exp_q[ch].size() != 0), DW'(1));
            if (exp_q[ch].size() != 0) begin
              beat_t b;
              b = exp_q[ch].pop_front();
              chk("m_data_data", m_data_data, b.data);
              chk("m_data_keep", DW'(m_data_keep), DW'(b.keep));
              chk("m_data_last", DW'(m_data_last), DW'(b.last));
              if (b.last) begin
                void'(grant_q.pop_front());
`ifdef ROCE_TX_STATS_EN
                exp_pkt_cnt[ch]++;
`endif
              end
            end
          end
        end
      end
    end
  end

  // Stimulus sequence
  initial begin
    bit found;
    int n;
    net_areset = 1'b1;
    s_meta_valid = '0; s_meta_has_data = '0; s_meta_data = '0;
    s_data_valid = '0; s_data_data = '0; s_data_keep = '0; s_data_last = '0;
    m_meta_ready = 1'b0; m_data_ready = 1'b0;
    rr_m = 0; occ_m = 1'b0; cnt_m = 0; saw_full = 1'b0;
    meta_hs = '0; data_hs = '0; gen_en = 1'b1;
    set_mix(0, 0, 0, 0);
    do_reset();

    // All channels requesting without payload: grants rotate 0,1,2,3,0,...
    set_mix(100, 0, 0, 100);
    run_cycles(10);

    // Mixed random traffic with backpressure
    set_mix(50, 60, 70, 70);
    run_cycles(400);

    // Payload withheld so grants pile up to a full FIFO; READ meta must still pass
    set_mix(60, 80, 0, 80);
    run_cycles(80);
    chk("fifo_full_reached", DW'(saw_full), DW'(1));

    // Drain-heavy traffic
    set_mix(30, 50, 100, 60);
    run_cycles(300);

    // Reset while a multi-beat packet is mid-flight
    set_mix(70, 90, 90, 80);
    found = 1'b0; n = 0;
    while (!found && n < 500) begin
      run_cycles(1);
      n++;
      if (m_data_valid && !m_data_last && grant_q.size() != 0 &&
          exp_q[grant_q[0]].size() != 0 && !exp_q[grant_q[0]][0].last) found = 1'b1;
    end
    chk("mid_packet_found", DW'(found), DW'(1));
    do_reset();

    // Traffic after reset: rotation restarts at channel 0
    set_mix(100, 0, 0, 100);
    run_cycles(6);
    set_mix(50, 60, 70, 70);
    run_cycles(300);

    // Stop new requests and let everything drain
    gen_en = 1'b0;
    set_mix(0, 0, 100, 100);
    n = 0;
    while ((meta_q.size() != 0 || grant_q.size() != 0 || s_meta_valid != '0) && n < 3000) begin
      run_cycles(1);
      n++;
    end
    chk("drain_done", DW'(meta_q.size() == 0 && grant_q.size() == 0), DW'(1));
    run_cycles(2);

`ifdef ROCE_TX_STATS_EN
    for (int c = 0; c < int'(N); c++) begin
      chk("stat_pkt_cnt", DW'(stat_pkt_cnt[c*32 +: 32]), DW'(exp_pkt_cnt[c]));
      chk("stat_meta_cnt", DW'(stat_meta_cnt[c*32 +: 32]), DW'(exp_meta_cnt[c]));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1);
  end

endmodule
